// File: rtl/divide_arbiter.sv
// Round-robin front end that shares one pipelined divider between N_REQ requesters.
// An in-order tag FIFO remembers who issued each divide so quotients are routed back.
module divide_arbiter #(
    parameter int N_REQ     = 4,
    parameter int D_WIDTH   = 32,
    parameter int Q_BITS    = 10,
    parameter int MAX_OUTST = 16,
    parameter int TAG_W     = $clog2(N_REQ)
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic [N_REQ-1:0]             req_valid,
    output logic [N_REQ-1:0]             req_ready,
    input  logic [N_REQ*D_WIDTH-1:0]     req_dividend,
    input  logic [N_REQ*D_WIDTH-1:0]     req_divisor,
    output logic [N_REQ-1:0]             res_valid,
    output logic [D_WIDTH-1:0]           res_quotient,
    output logic                         res_div0,
    output logic                         div_valid_in,
    output logic [D_WIDTH-1:0]           div_dividend,
    output logic [D_WIDTH-1:0]           div_divisor,
    input  logic                         div_valid_out,
    input  logic [D_WIDTH-1:0]           div_quotient,
    output logic [$clog2(MAX_OUTST):0]   outstanding,
    output logic                         err_underflow
);

    localparam int AW = $clog2(MAX_OUTST);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_COUNT = CW'(MAX_OUTST);

    generate
        if (N_REQ < 2 || (MAX_OUTST & (MAX_OUTST - 1)) != 0 || Q_BITS >= D_WIDTH) begin : g_bad_params
            $error("divide_arbiter: illegal parameter combination");
        end
    endgenerate

    logic [D_WIDTH-1:0] dividend_arr [N_REQ];
    logic [D_WIDTH-1:0] divisor_arr  [N_REQ];

    generate
        for (genvar gi = 0; gi < N_REQ; gi++) begin : g_unpack
            assign dividend_arr[gi] = req_dividend[gi*D_WIDTH +: D_WIDTH];
            assign divisor_arr[gi]  = req_divisor[gi*D_WIDTH +: D_WIDTH];
        end
    endgenerate

    // Tag entry layout: {requester id, divisor_was_zero}
    logic [TAG_W:0]       tag_mem [MAX_OUTST];

    logic [TAG_W-1:0]     ptr_q, ptr_d;
    logic [AW-1:0]        wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]        rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]        count_q, count_d;
    logic [N_REQ-1:0]     res_valid_q, res_valid_d;
    logic [D_WIDTH-1:0]   res_quotient_q, res_quotient_d;
    logic                 res_div0_q, res_div0_d;
    logic                 div_valid_in_q, div_valid_in_d;
    logic [D_WIDTH-1:0]   div_dividend_q, div_dividend_d;
    logic [D_WIDTH-1:0]   div_divisor_q, div_divisor_d;
    logic                 err_underflow_q, err_underflow_d;

    logic                 grant_found;
    logic [TAG_W-1:0]     grant_idx;
    logic [TAG_W-1:0]     cand_idx;
    logic                 grant_div0;
    int                   cand;
    logic                 fifo_empty;
    logic                 pop;
    logic [TAG_W:0]       head;
    logic [TAG_W-1:0]     head_id;
    logic                 head_z;

    assign fifo_empty = (count_q == '0);
    assign pop        = div_valid_out && !fifo_empty;
    assign head       = tag_mem[rd_ptr_q];
    assign head_id    = head[TAG_W:1];
    assign head_z     = head[0];

    // Rotating priority search starting at ptr_q; no grant at all while full.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        cand        = 0;
        cand_idx    = '0;
        req_ready   = '0;
        if (count_q < FULL_COUNT) begin
            for (int k = 0; k < N_REQ; k++) begin
                cand = int'(ptr_q) + k;
                if (cand >= N_REQ) begin
                    cand = cand - N_REQ;
                end
                cand_idx = TAG_W'(cand);
                if (!grant_found && req_valid[cand_idx]) begin
                    grant_found = 1'b1;
                    grant_idx   = cand_idx;
                end
            end
        end
        if (grant_found) begin
            req_ready[grant_idx] = 1'b1;
        end
    end

    assign grant_div0 = (divisor_arr[grant_idx] == '0);

    always_comb begin
        ptr_d           = ptr_q;
        wr_ptr_d        = wr_ptr_q;
        rd_ptr_d        = rd_ptr_q;
        count_d         = count_q;
        div_valid_in_d  = grant_found;
        div_dividend_d  = div_dividend_q;
        div_divisor_d   = div_divisor_q;
        res_valid_d     = '0;
        res_quotient_d  = res_quotient_q;
        res_div0_d      = 1'b0;
        err_underflow_d = err_underflow_q;

        if (grant_found) begin
            div_dividend_d = dividend_arr[grant_idx];
            div_divisor_d  = divisor_arr[grant_idx];
            wr_ptr_d       = wr_ptr_q + AW'(1);
            ptr_d          = (grant_idx == TAG_W'(N_REQ - 1)) ? '0 : grant_idx + TAG_W'(1);
        end

        if (pop) begin
            rd_ptr_d             = rd_ptr_q + AW'(1);
            res_valid_d[head_id] = 1'b1;
            res_quotient_d       = div_quotient;
            res_div0_d           = head_z;
        end else if (div_valid_out) begin
            err_underflow_d = 1'b1;
        end

        unique case ({grant_found, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clock) begin
        if (grant_found) begin
            tag_mem[wr_ptr_q] <= {grant_idx, grant_div0};
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            ptr_q           <= '0;
            wr_ptr_q        <= '0;
            rd_ptr_q        <= '0;
            count_q         <= '0;
            res_valid_q     <= '0;
            res_quotient_q  <= '0;
            res_div0_q      <= 1'b0;
            div_valid_in_q  <= 1'b0;
            div_dividend_q  <= '0;
            div_divisor_q   <= '0;
            err_underflow_q <= 1'b0;
        end else begin
            ptr_q           <= ptr_d;
            wr_ptr_q        <= wr_ptr_d;
            rd_ptr_q        <= rd_ptr_d;
            count_q         <= count_d;
            res_valid_q     <= res_valid_d;
            res_quotient_q  <= res_quotient_d;
            res_div0_q      <= res_div0_d;
            div_valid_in_q  <= div_valid_in_d;
            div_dividend_q  <= div_dividend_d;
            div_divisor_q   <= div_divisor_d;
            err_underflow_q <= err_underflow_d;
        end
    end

    assign res_valid     = res_valid_q;
    assign res_quotient  = res_quotient_q;
    assign res_div0      = res_div0_q;
    assign div_valid_in  = div_valid_in_q;
    assign div_dividend  = div_dividend_q;
    assign div_divisor   = div_divisor_q;
    assign outstanding   = count_q;
    assign err_underflow = err_underflow_q;

endmodule

// File: tb/tb_divide_arbiter.sv
// Directed bench for divide_arbiter with a behavioural fixed-latency divider
// that can be stalled or made to emit a stray result.
module tb_divide_arbiter;

    localparam int N       = 4;
    localparam int DW      = 32;
    localparam int QB      = 10;
    localparam int MO      = 16;
    localparam int DIV_LAT = 2;

    logic              clock = 1'b0;
    logic              reset = 1'b1;
    logic [N-1:0]      req_valid = '0;
    logic [N-1:0]      req_ready;
    logic [N*DW-1:0]   req_dividend = '0;
    logic [N*DW-1:0]   req_divisor = '0;
    logic [N-1:0]      res_valid;
    logic [DW-1:0]     res_quotient;
    logic              res_div0;
    logic              div_valid_in;
    logic [DW-1:0]     div_dividend;
    logic [DW-1:0]     div_divisor;
    logic              div_valid_out = 1'b0;
    logic [DW-1:0]     div_quotient = '0;
    logic [4:0]        outstanding;
    logic              err_underflow;

    divide_arbiter #(.N_REQ(N), .D_WIDTH(DW), .Q_BITS(QB), .MAX_OUTST(MO)) dut (
        .clock(clock), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_dividend(req_dividend), .req_divisor(req_divisor),
        .res_valid(res_valid), .res_quotient(res_quotient), .res_div0(res_div0),
        .div_valid_in(div_valid_in), .div_dividend(div_dividend), .div_divisor(div_divisor),
        .div_valid_out(div_valid_out), .div_quotient(div_quotient),
        .outstanding(outstanding), .err_underflow(err_underflow)
    );

    always #5 clock = ~clock;

    typedef struct { logic [DW-1:0] a; logic [DW-1:0] b; int c; } op_t;
    typedef struct { logic [N-1:0] v; logic [DW-1:0] q; logic z; } res_t;
    typedef struct { logic [N-1:0] valid; logic [N-1:0] exp_ready; } vec_t;

    op_t         div_q[$];
    res_t        res_log[$];
    int          cyc_n = 0;
    logic        stall = 1'b0;
    logic        spur_req = 1'b0;
    logic [DW-1:0] op_a [N];
    logic [DW-1:0] op_b [N];
    vec_t        tbl [12];
    int          n_checks = 0;
    int          n_fail = 0;

    function automatic logic [DW-1:0] model_q(input logic [DW-1:0] a, input logic [DW-1:0] b);
        longint num;
        longint q;
        if (b == '0) return 32'hFFFF_FFFF;
        num = longint'($signed(a)) <<< QB;
        q   = num / longint'($signed(b));
        return q[DW-1:0];
    endfunction

    function automatic int onehot_idx(input logic [N-1:0] v);
        for (int i = 0; i < N; i++) if (v[i]) return i;
        return 0;
    endfunction

    // Divider stand-in plus result recorder, all on the falling edge.
    always @(negedge clock) begin
        cyc_n = cyc_n + 1;
        if (|res_valid) res_log.push_back('{v: res_valid, q: res_quotient, z: res_div0});
        if (reset) begin
            div_q.delete();
            div_valid_out = 1'b0;
        end else begin
            if (div_valid_in) div_q.push_back('{a: div_dividend, b: div_divisor, c: cyc_n});
            if (spur_req) begin
                div_valid_out = 1'b1;
                div_quotient  = 32'hDEAD_BEEF;
            end else if (!stall && div_q.size() > 0 && (cyc_n - div_q[0].c) >= DIV_LAT) begin
                div_valid_out = 1'b1;
                div_quotient  = model_q(div_q[0].a, div_q[0].b);
                void'(div_q.pop_front());
            end else begin
                div_valid_out = 1'b0;
            end
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_res(input int idx, input logic [N-1:0] v, input logic [DW-1:0] q,
                             input logic z, input string name);
        if (idx >= res_log.size()) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s: result missing, got %0d results, needed index %0d", name, res_log.size(), idx);
        end else begin
            check({name, "_valid"}, res_log[idx].v, v);
            check({name, "_quot"},  res_log[idx].q, q);
            check({name, "_div0"},  res_log[idx].z, z);
        end
    endtask

    task automatic next();
        @(posedge clock);
        #1;
    endtask

    task automatic drive_ops();
        for (int i = 0; i < N; i++) begin
            req_dividend[i*DW +: DW] = op_a[i];
            req_divisor[i*DW +: DW]  = op_b[i];
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        next();
        next();
        reset = 1'b0;
    endtask

    task automatic wait_res(input int base, input int n);
        int t;
        t = 0;
        while (res_log.size() < base + n && t < 200) begin
            next();
            t++;
        end
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        int base;
        int exp_ids[$];
        logic [N-1:0] onehot;

        for (int i = 0; i < N; i++) begin
            op_a[i] = DW'((190 + 50 * i) << 10);
            op_b[i] = DW'((7 + 2 * i) << 10);
        end
        drive_ops();
        tbl[0]  = '{4'b0000, 4'b0000};
        tbl[1]  = '{4'b0100, 4'b0100};
        tbl[2]  = '{4'b0111, 4'b0001};
        tbl[3]  = '{4'b1111, 4'b0010};
        tbl[4]  = '{4'b1010, 4'b1000};
        tbl[5]  = '{4'b1010, 4'b0010};
        tbl[6]  = '{4'b0001, 4'b0001};
        tbl[7]  = '{4'b1000, 4'b1000};
        tbl[8]  = '{4'b0110, 4'b0010};
        tbl[9]  = '{4'b0110, 4'b0100};
        tbl[10] = '{4'b0011, 4'b0001};
        tbl[11] = '{4'b0000, 4'b0000};

        // Reset state
        repeat (3) @(posedge clock);
        #1;
        check("rst_ready", req_ready, 0);
        check("rst_res_valid", res_valid, 0);
        check("rst_res_quot", res_quotient, 0);
        check("rst_res_div0", res_div0, 0);
        check("rst_div_valid", div_valid_in, 0);
        check("rst_div_dividend", div_dividend, 0);
        check("rst_div_divisor", div_divisor, 0);
        check("rst_outstanding", outstanding, 0);
        check("rst_underflow", err_underflow, 0);
        reset = 1'b0;

        // Single request from requester 0: 190.0 / 7.0 in Q10
        base = res_log.size();
        req_valid = 4'b0001;
        #1 check("t1_ready", req_ready, 4'b0001);
        next();
        req_valid = 4'b0000;
        check("t1_issue", div_valid_in, 1);
        check("t1_dividend", div_dividend, 32'd194560);
        check("t1_divisor", div_divisor, 32'd7168);
        check("t1_outst_1", outstanding, 1);
        wait_res(base, 1);
        check_res(base, 4'b0001, 32'd27794, 1'b0, "t1_res");
        check("t1_outst_0", outstanding, 0);
        check("t1_count", res_log.size(), base + 1);

        // Table of request patterns walking the round-robin pointer
        do_reset();
        base = res_log.size();
        exp_ids.delete();
        for (int i = 0; i < 12; i++) begin
            req_valid = tbl[i].valid;
            #1 check($sformatf("tbl%0d_ready", i), req_ready, tbl[i].exp_ready);
            next();
            check($sformatf("tbl%0d_issue", i), div_valid_in, tbl[i].exp_ready != 0);
            if (tbl[i].exp_ready != 0) begin
                check($sformatf("tbl%0d_divisor", i), div_divisor, op_b[onehot_idx(tbl[i].exp_ready)]);
                exp_ids.push_back(onehot_idx(tbl[i].exp_ready));
            end
        end
        req_valid = '0;
        wait_res(base, exp_ids.size());
        foreach (exp_ids[k]) begin
            onehot = N'(1) << exp_ids[k];
            check_res(base + k, onehot, model_q(op_a[exp_ids[k]], op_b[exp_ids[k]]), 1'b0,
                      $sformatf("tbl_res%0d", k));
        end

        // All requesters valid for 16 cycles: strict rotation
        do_reset();
        base = res_log.size();
        req_valid = 4'b1111;
        for (int k = 0; k < 16; k++) begin
            onehot = N'(1) << (k % N);
            #1 check($sformatf("rr%0d_ready", k), req_ready, onehot);
            next();
        end
        req_valid = '0;
        wait_res(base, 16);
        for (int k = 0; k < 16; k++) begin
            onehot = N'(1) << (k % N);
            check_res(base + k, onehot, model_q(op_a[k % N], op_b[k % N]), 1'b0, $sformatf("rr_res%0d", k));
        end

        // Fill to MAX_OUTST with the divider stalled
        do_reset();
        base = res_log.size();
        stall = 1'b1;
        req_valid = 4'b1111;
        for (int k = 0; k < 16; k++) begin
            onehot = N'(1) << (k % N);
            #1 check($sformatf("full%0d_ready", k), req_ready, onehot);
            next();
        end
        check("full_outst", outstanding, 16);
        check("full_ready_0", req_ready, 0);
        next();
        check("full_ready_1", req_ready, 0);
        stall = 1'b0;
        @(negedge clock);
        #1 check("full_with_pop_ready", req_ready, 0);
        @(posedge clock);
        #1;
        check("after_pop_outst", outstanding, 15);
        check("after_pop_ready", req_ready, 4'b0001);
        req_valid = '0;
        wait_res(base, 16);
        for (int k = 0; k < 16; k++) begin
            onehot = N'(1) << (k % N);
            check_res(base + k, onehot, model_q(op_a[k % N], op_b[k % N]), 1'b0, $sformatf("full_res%0d", k));
        end
        check("full_drained", outstanding, 0);

        // Divide by zero on requester 2
        do_reset();
        base = res_log.size();
        op_b[2] = '0;
        drive_ops();
        req_valid = 4'b1110;
        for (int k = 0; k < 3; k++) begin
            onehot = N'(2) << k;
            #1 check($sformatf("dz%0d_ready", k), req_ready, onehot);
            next();
        end
        req_valid = '0;
        wait_res(base, 3);
        check_res(base,     4'b0010, model_q(op_a[1], op_b[1]), 1'b0, "dz_res1");
        check_res(base + 1, 4'b0100, 32'hFFFF_FFFF,             1'b1, "dz_res2");
        check_res(base + 2, 4'b1000, model_q(op_a[3], op_b[3]), 1'b0, "dz_res3");
        op_b[2] = DW'((7 + 4) << 10);
        drive_ops();

        // Stray divider result with nothing in flight
        do_reset();
        base = res_log.size();
        spur_req = 1'b1;
        @(negedge clock);
        #1 spur_req = 1'b0;
        @(posedge clock);
        #1;
        check("uf_flag", err_underflow, 1);
        check("uf_res_valid", res_valid, 0);
        check("uf_outst", outstanding, 0);
        next();
        next();
        check("uf_sticky", err_underflow, 1);
        check("uf_no_result", res_log.size(), base);
        do_reset();
        check("uf_cleared", err_underflow, 0);

        // Reset with five divides in flight
        do_reset();
        stall = 1'b1;
        req_valid = 4'b1111;
        repeat (5) next();
        req_valid = '0;
        check("rm_outst_5", outstanding, 5);
        base = res_log.size();
        reset = 1'b1;
        next();
        check("rm_outst_0", outstanding, 0);
        check("rm_res_valid", res_valid, 0);
        check("rm_div_valid", div_valid_in, 0);
        reset = 1'b0;
        stall = 1'b0;
        repeat (10) next();
        check("rm_no_results", res_log.size(), base);
        check("rm_outst_idle", outstanding, 0);
        req_valid = 4'b0101;
        #1 check("rm_first_grant", req_ready, 4'b0001);
        next();
        req_valid = '0;
        wait_res(base, 1);
        check_res(base, 4'b0001, model_q(op_a[0], op_b[0]), 1'b0, "rm_res");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
